booth_radix4_seq_mult: RTL and testbench
========================================

# booth_radix4_seq_mult

Parametrised sequential radix-4 Booth multiplier, the next generation of the lab's 8-bit serial Booth multiplier. It adds a generic operand width, a start/busy/valid handshake in place of reset-triggered operation, and optional signed/unsigned mode. It retires one radix-4 digit per clock. Datapath blocks use it as a shared low-area multiply unit wherever a multi-cycle latency is acceptable.

## Interface
Parameters:
- W, default 8: operand width. Must be even and ≥ 4.

Ports:
- clk, input, 1: clock, rising-edge.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: request a multiply. Sampled only while idle.
- in_a, input, W: multiplicand, sampled at the accepting edge.
- in_b, input, W: multiplier, sampled at the accepting edge.
- is_signed, input, 1: 1 = two's-complement operands, 0 = unsigned. Sampled at the accepting edge. Present only with BOOTH_SIGNED_EN.
- busy, output, 1: high while an operation is in progress.
- out, output, 2W: product, held stable until the next result.
- out_valid, output, 1: one-cycle pulse marking a new value on out.

## Operation
- States: IDLE, CALC. Reset state is IDLE.
- IDLE with start=1: latch the operands and go to CALC.
  - Operands are extended to W+2 bits: sign-extended if signed, zero-extended if unsigned.
  - The Booth bit b[-1] is set to 0.
  - The iteration counter is cleared.
- CALC, each cycle:
  - Recode the multiplier triplet {b[2i+1], b[2i], b[2i-1]} into a digit: 000/111 → 0, 001/010 → +A, 011 → +2A, 100 → −2A, 101/110 → −A.
  - Add the digit to the upper accumulator bits.
  - Arithmetic-shift the accumulator/multiplier pair right by 2.
- Iteration count is N = W/2 + 1. The extra digit makes unsigned W-bit operands exact.
- After iteration N:
  - out ← low 2W bits of the exact product.
  - out_valid pulses.
  - State returns to IDLE.
- The internal accumulator is wide enough that no intermediate overflow occurs: W+3 bits for the partial-sum field.
- out is the exact 2W-bit product: two's complement if signed, plain binary if unsigned. Truncation never loses information.
- start while in CALC is ignored. No queueing is performed.

## Timing
- Reset values: busy=0, out=0, out_valid=0, state IDLE. All internal registers are cleared.
- Let start be accepted at edge T0.
  - busy is 1 from T0 until T0+N.
  - out and out_valid=1 update at edge T0+N.
  - out_valid falls at T0+N+1 unless a new result completes then.
- Latency is N cycles from the accepting edge: 5 for W=8, 9 for W=16.
- Back-to-back: start=1 in the cycle where out_valid=1 is accepted at T0+N+1. Throughput is one product per N+1 cycles.
- Operand inputs may change freely after the accepting edge.
- rst asserted mid-operation aborts immediately:
  - out_valid stays 0.
  - out is cleared to 0.
  - No partial result is ever emitted.
- start held high continuously: the unit restarts on every IDLE cycle, operating on the inputs present at each accepting edge.

## Configuration
- BOOTH_SIGNED_EN defined:
  - The is_signed port exists.
  - Operand extension follows is_signed as latched at the accepting edge.
- BOOTH_SIGNED_EN undefined:
  - The is_signed port is absent.
  - The unit is unsigned-only and always zero-extends.
- Latency and handshake are identical in both builds.

## Test plan
- W=8, unsigned: 3×9 → out=27 at start edge + 5. out_valid high for exactly 1 cycle. busy high for 5 cycles.
- W=8, unsigned corner cases: 25×0 → 0; 255×255 → 65025; 100×14 → 1400; 123×12 → 1476; 45×69 → 3105.
- W=8, BOOTH_SIGNED_EN, is_signed=1:
  - −3×9 → 16'hFFE5.
  - −128×−128 → 16384.
  - 127×−128 → 16'hC080.
- Handshake:
  - start pulsed during CALC (cycle 2) is ignored and the first result is unaffected.
  - start in the out_valid cycle launches a second multiply: 7×6=42, then 10×10=100 five cycles later.
- Reset at cycle 3 of 200×200: out=0 and out_valid never pulses. A subsequent 2×2 completes with 4.
- W=16, unsigned: 65535×65535 → 32'hFFFE0001 at latency 9. Signed build: −1×−1 → 1.

Source files
------------

// File: rtl/booth_radix4_seq_mult_if.sv
// Handshake/bus bundle for booth_radix4_seq_mult.
// BOOTH_SIGNED_EN adds the is_signed request field.
interface booth_radix4_seq_mult_if #(
    parameter int unsigned W = 8
);
    logic           start;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
`ifdef BOOTH_SIGNED_EN
    logic           is_signed;
`endif
    logic           busy;
    logic [2*W-1:0] out;
    logic           out_valid;

`ifdef BOOTH_SIGNED_EN
    modport master (output start, in_a, in_b, is_signed, input busy, out, out_valid);
    modport slave  (input start, in_a, in_b, is_signed, output busy, out, out_valid);
`else
    modport master (output start, in_a, in_b, input busy, out, out_valid);
    modport slave  (input start, in_a, in_b, output busy, out, out_valid);
`endif
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per clock, W/2+1 digits.
// Optional feature macro: BOOTH_SIGNED_EN (adds two's-complement mode via is_signed).
module booth_radix4_seq_mult #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst,
    booth_radix4_seq_mult_if.slave bus
);
    localparam int unsigned XW = W + 2;          // extended operand width
    localparam int unsigned PW = W + 3;          // partial-sum field width
    localparam int unsigned N  = W / 2 + 1;      // digits per product
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [2*W-1:0]  out_q, out_d;
    logic [XW-1:0]   a_q, a_d;
    logic [XW-1:0]   mul_q, mul_d;
    logic            bm1_q, bm1_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sx_a, sx_b;
    logic [PW-1:0]   a1, a2, addend, sum, sum_sh;

    // Operand extension bits: sign copy in signed mode, zero otherwise.
    always_comb begin
`ifdef BOOTH_SIGNED_EN
        sx_a = bus.is_signed & bus.in_a[W-1];
        sx_b = bus.is_signed & bus.in_b[W-1];
`else
        sx_a = 1'b0;
        sx_b = 1'b0;
`endif
    end

    // Booth digit recode, partial-sum add and the next-state/output logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        out_d       = out_q;
        a_d         = a_q;
        mul_d       = mul_q;
        bm1_d       = bm1_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        a1 = {a_q[XW-1], a_q};
        a2 = {a_q, 1'b0};
        case ({mul_q[1:0], bm1_q})
            3'b001, 3'b010: addend = a1;
            3'b011:         addend = a2;
            3'b100:         addend = -a2;
            3'b101, 3'b110: addend = -a1;
            default:        addend = '0;
        endcase
        sum    = acc_q + addend;
        sum_sh = {{2{sum[PW-1]}}, sum[PW-1:2]};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    a_d     = {{2{sx_a}}, bus.in_a};
                    mul_d   = {{2{sx_b}}, bus.in_b};
                    bm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d = sum_sh;
                mul_d = {sum[1:0], mul_q[XW-1:2]};
                bm1_d = mul_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    out_d       = (2*W)'({sum_sh, sum[1:0], mul_q[XW-1:2]});
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            a_q         <= '0;
            mul_q       <= '0;
            bm1_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            a_q         <= a_d;
            mul_q       <= mul_d;
            bm1_q       <= bm1_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Bench for booth_radix4_seq_mult: W=8 and W=16 instances checked against an arithmetic model.
module tb_booth_radix4_seq_mult;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_radix4_seq_mult_if #(.W(8))  bus8 ();
    booth_radix4_seq_mult_if #(.W(16)) bus16 ();

    booth_radix4_seq_mult #(.W(8))  u8  (.clk(clk), .rst(rst), .bus(bus8));
    booth_radix4_seq_mult #(.W(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic        sgn_mode = 1'b0;
    logic [31:0] last_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit wide, input logic st, input logic [15:0] a, input logic [15:0] b);
        if (wide) begin
            bus16.start = st; bus16.in_a = a; bus16.in_b = b;
        end else begin
            bus8.start = st; bus8.in_a = a[7:0]; bus8.in_b = b[7:0];
        end
`ifdef BOOTH_SIGNED_EN
        if (wide) bus16.is_signed = sgn_mode;
        else      bus8.is_signed  = sgn_mode;
`endif
    endtask

    function automatic logic [31:0] obs_out(input bit wide);
        return wide ? bus16.out : {16'h0, bus8.out};
    endfunction
    function automatic logic [31:0] obs_busy(input bit wide);
        return {31'h0, wide ? bus16.busy : bus8.busy};
    endfunction
    function automatic logic [31:0] obs_valid(input bit wide);
        return {31'h0, wide ? bus16.out_valid : bus8.out_valid};
    endfunction

    // Reference: plain integer product of the interpreted operands, truncated to 2W bits.
    function automatic logic [31:0] model(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic sg);
        longint va, vb, p;
        if (wide) begin
            va = sg ? longint'($signed(a)) : longint'(a);
            vb = sg ? longint'($signed(b)) : longint'(b);
        end else begin
            va = sg ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            vb = sg ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end
        p = va * vb;
        return wide ? p[31:0] : {16'h0, p[15:0]};
    endfunction

    // One multiply from request to result; entered and left at #1 after a rising edge.
    task automatic run(input bit wide, input logic [15:0] a, input logic [15:0] b, input bit poke, input string tag);
        int n;
        logic [31:0] exp;
        n   = wide ? 9 : 5;
        exp = model(wide, a, b, sgn_mode);
        drive(wide, 1'b1, a, b);
        @(posedge clk); #1;
        drive(wide, 1'b0, 16'($urandom), 16'($urandom));
        chk({tag, " busy@T0"}, obs_busy(wide), 32'd1);
        for (int k = 1; k < n; k++) begin
            @(posedge clk); #1;
            drive(wide, poke && (k == 1), 16'($urandom), 16'($urandom));
            chk({tag, " busy"}, obs_busy(wide), 32'd1);
            chk({tag, " early_valid"}, obs_valid(wide), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, " valid"}, obs_valid(wide), 32'd1);
        chk({tag, " out"}, obs_out(wide), exp);
        chk({tag, " busy_done"}, obs_busy(wide), 32'd0);
        last_exp = exp;
    endtask

    task automatic idle_check(input bit wide, input string tag);
        drive(wide, 1'b0, 16'($urandom), 16'($urandom));
        @(posedge clk); #1;
        chk({tag, " valid_drop"}, obs_valid(wide), 32'd0);
        chk({tag, " busy_idle"}, obs_busy(wide), 32'd0);
        chk({tag, " out_hold"}, obs_out(wide), last_exp);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        chk("rst out8", obs_out(1'b0), 32'd0);
        chk("rst valid8", obs_valid(1'b0), 32'd0);
        chk("rst busy8", obs_busy(1'b0), 32'd0);
        chk("rst out16", obs_out(1'b1), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed unsigned W=8 cases.
        sgn_mode = 1'b0;
        run(1'b0, 16'd3, 16'd9, 1'b0, "3x9");      idle_check(1'b0, "3x9");
        run(1'b0, 16'd25, 16'd0, 1'b0, "25x0");    idle_check(1'b0, "25x0");
        run(1'b0, 16'd255, 16'd255, 1'b0, "255x255"); idle_check(1'b0, "255x255");
        run(1'b0, 16'd100, 16'd14, 1'b0, "100x14"); idle_check(1'b0, "100x14");
        run(1'b0, 16'd123, 16'd12, 1'b0, "123x12"); idle_check(1'b0, "123x12");
        run(1'b0, 16'd45, 16'd69, 1'b0, "45x69");   idle_check(1'b0, "45x69");

        // start during CALC must be ignored.
        run(1'b0, 16'd11, 16'd13, 1'b1, "poke");    idle_check(1'b0, "poke");

        // Back-to-back: second start in the out_valid cycle.
        run(1'b0, 16'd7, 16'd6, 1'b0, "b2b_1");
        run(1'b0, 16'd10, 16'd10, 1'b0, "b2b_2");   idle_check(1'b0, "b2b_2");

        // Reset three cycles into 200x200 aborts without a result.
        drive(1'b0, 1'b1, 16'd200, 16'd200);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("abort out", obs_out(1'b0), 32'd0);
        chk("abort valid", obs_valid(1'b0), 32'd0);
        chk("abort busy", obs_busy(1'b0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus8.out_valid) seen = 1'b1;
        end
        chk("abort no_pulse", {31'h0, seen}, 32'd0);
        chk("abort out_zero", obs_out(1'b0), 32'd0);
        run(1'b0, 16'd2, 16'd2, 1'b0, "after_rst"); idle_check(1'b0, "after_rst");

        // W=16 unsigned corner.
        run(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "w16_max"); idle_check(1'b1, "w16_max");

`ifdef BOOTH_SIGNED_EN
        sgn_mode = 1'b1;
        run(1'b0, 16'h00FD, 16'h0009, 1'b0, "s_m3x9");      idle_check(1'b0, "s_m3x9");
        run(1'b0, 16'h0080, 16'h0080, 1'b0, "s_m128sq");    idle_check(1'b0, "s_m128sq");
        run(1'b0, 16'h007F, 16'h0080, 1'b0, "s_127xm128");  idle_check(1'b0, "s_127xm128");
        run(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "s_w16_m1sq");  idle_check(1'b1, "s_w16_m1sq");
`endif

        // Randomised operands on both widths.
        for (int i = 0; i < 20; i++) begin
`ifdef BOOTH_SIGNED_EN
            sgn_mode = 1'($urandom);
`endif
            run(1'b0, 16'($urandom), 16'($urandom), 1'b0, "rand8");
        end
        idle_check(1'b0, "rand8");
        for (int i = 0; i < 10; i++) begin
`ifdef BOOTH_SIGNED_EN
            sgn_mode = 1'($urandom);
`endif
            run(1'b1, 16'($urandom), 16'($urandom), 1'b0, "rand16");
        end
        idle_check(1'b1, "rand16");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
